// File: rtl/run_ctrl.sv
// run_ctrl: start/stop sequencer for NUM_CORES single-cycle MIPS cores.
// Holds core reset for RST_HOLD cycles after start, then counts RUN cycles
// until every core has parked its PC (halt) or MAX_CYCLES elapse (timeout).
// Optional feature macro: RUN_CTRL_HALT_PC_EN adds the halt_pc output, which
// captures each core's PC on the edge its halted flag sets.
module run_ctrl #(
    parameter int unsigned NUM_CORES   = 1,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned RST_HOLD    = 4,
    parameter int unsigned HALT_REPEAT = 3,
    parameter int unsigned MAX_CYCLES  = 100000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NUM_CORES*PC_W-1:0] core_pc,
    output logic [NUM_CORES-1:0]      core_rst,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout,
    output logic [NUM_CORES-1:0]      halted,
    output logic [CNT_W-1:0]          cycle_cnt
`ifdef RUN_CTRL_HALT_PC_EN
    ,
    output logic [NUM_CORES*PC_W-1:0] halt_pc
`endif
);

    localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int unsigned STB_W  = $clog2(HALT_REPEAT + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [STB_W-1:0]  STB_MAX   = STB_W'(HALT_REPEAT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    state_t                              state_q, state_d;
    logic [HOLD_W-1:0]                   hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]                    cycle_cnt_q, cycle_cnt_d;
    logic [NUM_CORES-1:0]                halted_q, halted_d;
    logic                                timeout_q, timeout_d;
    logic                                busy_q, busy_d;
    logic                                done_q, done_d;
    logic [NUM_CORES-1:0]                core_rst_q, core_rst_d;
    logic [NUM_CORES-1:0][PC_W-1:0]      prev_pc_q, prev_pc_d;
    logic [NUM_CORES-1:0]                pc_valid_q, pc_valid_d;
    logic [NUM_CORES-1:0][STB_W-1:0]     stable_q, stable_d;

    logic                                start_go;
    logic [NUM_CORES-1:0]                halt_set;

    assign start_go = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Next-state, counters, halt detection and registered output values
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        halted_d    = halted_q;
        timeout_d   = timeout_q;
        busy_d      = busy_q;
        done_d      = done_q;
        core_rst_d  = core_rst_q;
        prev_pc_d   = prev_pc_q;
        pc_valid_d  = pc_valid_q;
        stable_d    = stable_q;
        halt_set    = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_go) begin
                    state_d     = S_HOLD;
                    hold_cnt_d  = '0;
                    cycle_cnt_d = '0;
                    halted_d    = '0;
                    timeout_d   = 1'b0;
                    stable_d    = '0;
                    pc_valid_d  = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    core_rst_d  = '1;
                end
            end

            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = S_RUN;
                    core_rst_d = '0;
                    pc_valid_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            S_RUN: begin
                cycle_cnt_d = cycle_cnt_q + 1'b1;
                for (int unsigned i = 0; i < NUM_CORES; i++) begin
                    prev_pc_d[i]  = core_pc[i*PC_W +: PC_W];
                    pc_valid_d[i] = 1'b1;
                    if (pc_valid_q[i] && (core_pc[i*PC_W +: PC_W] == prev_pc_q[i])) begin
                        // Saturate so a long-parked core never wraps the counter
                        stable_d[i] = (stable_q[i] == STB_MAX) ? STB_MAX : stable_q[i] + 1'b1;
                    end else begin
                        stable_d[i] = '0;
                    end
                    if (!halted_q[i] && (stable_d[i] == STB_MAX)) begin
                        halt_set[i] = 1'b1;
                    end
                end
                halted_d = halted_q | halt_set;

                // Halt takes priority over a timeout landing on the same edge
                if (&halted_d) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else if (cycle_cnt_d == CNT_MAX) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers; async reset parks cores in reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            hold_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            halted_q    <= '0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            core_rst_q  <= '1;
            prev_pc_q   <= '0;
            pc_valid_q  <= '0;
            stable_q    <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            halted_q    <= halted_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            core_rst_q  <= core_rst_d;
            prev_pc_q   <= prev_pc_d;
            pc_valid_q  <= pc_valid_d;
            stable_q    <= stable_d;
        end
    end

    assign core_rst  = core_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign halted    = halted_q;
    assign cycle_cnt = cycle_cnt_q;

`ifdef RUN_CTRL_HALT_PC_EN
    logic [NUM_CORES-1:0][PC_W-1:0] halt_pc_q, halt_pc_d;

    // Capture each core's parked PC on the edge its halt flag sets
    always_comb begin
        halt_pc_d = halt_pc_q;
        if (start_go) begin
            halt_pc_d = '0;
        end
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (halt_set[i]) begin
                halt_pc_d[i] = core_pc[i*PC_W +: PC_W];
            end
        end
    end

    // Halt-PC capture registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halt_pc_q <= '0;
        end else begin
            halt_pc_q <= halt_pc_d;
        end
    end

    assign halt_pc = halt_pc_q;
`else
    // No halt-PC capture: halt_set only feeds the halted flags
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: four cores, short hold/halt/timeout limits.
// Stimulus pushes hand-computed halt events and run results; a monitor pops
// them as halted changes and as done rises.
module tb_run_ctrl;

    localparam int unsigned NC = 4;
    localparam int unsigned PW = 32;
    localparam int unsigned CW = 16;
    localparam int unsigned RH = 4;
    localparam int unsigned HR = 3;
    localparam int unsigned MC = 50;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [NC*PW-1:0]     core_pc;
    logic [NC-1:0]        core_rst;
    logic                 busy;
    logic                 done;
    logic                 timeout;
    logic [NC-1:0]        halted;
    logic [CW-1:0]        cycle_cnt;
`ifdef RUN_CTRL_HALT_PC_EN
    logic [NC*PW-1:0]     halt_pc;
`endif

    always #5 clk = ~clk;

    run_ctrl #(
        .NUM_CORES  (NC),
        .PC_W       (PW),
        .CNT_W      (CW),
        .RST_HOLD   (RH),
        .HALT_REPEAT(HR),
        .MAX_CYCLES (MC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .core_pc  (core_pc),
        .core_rst (core_rst),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .halted   (halted),
        .cycle_cnt(cycle_cnt)
`ifdef RUN_CTRL_HALT_PC_EN
        ,
        .halt_pc  (halt_pc)
`endif
    );

    typedef struct {
        logic [NC-1:0] halted;
        logic [CW-1:0] cnt;
    } halt_exp_t;

    typedef struct {
        logic          to;
        logic [NC-1:0] halted;
        logic [CW-1:0] cnt;
        logic [NC*PW-1:0] hpc;
    } done_exp_t;

    halt_exp_t hq[$];
    done_exp_t dq[$];

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares halted progressions and run results as they appear
    logic [NC-1:0] mon_prev_h = '0;
    logic          mon_prev_d = 1'b0;
    halt_exp_t     mon_he;
    done_exp_t     mon_de;

    initial begin
        forever begin
            @(negedge clk);
            if (done) check("done_busy_exclusive", busy, 0);
            if (halted !== mon_prev_h && halted !== '0) begin
                if (hq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL halt_unexpected: got halted=%b expected no change", halted);
                end else begin
                    mon_he = hq.pop_front();
                    check("halt_bits", halted, mon_he.halted);
                    check("halt_cycle", cycle_cnt, mon_he.cnt);
                end
            end
            if (done && !mon_prev_d) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: got done=1 expected no completion");
                end else begin
                    mon_de = dq.pop_front();
                    check("done_timeout", timeout, mon_de.to);
                    check("done_halted", halted, mon_de.halted);
                    check("done_cycle_cnt", cycle_cnt, mon_de.cnt);
`ifdef RUN_CTRL_HALT_PC_EN
                    check("done_halt_pc", halt_pc, mon_de.hpc);
`endif
                end
            end
            mon_prev_h = halted;
            mon_prev_d = done;
        end
    end

    // One run: park[i] = PC step index where core i stops (255 = never).
    // ign_n: edge index (0 = start edge) of an extra start pulse, -1 = none.
    // abort_n: edge index after which reset is pulled asynchronously, -1 = none.
    task automatic do_run(input logic [NC-1:0][7:0] park, input int ign_n, input int abort_n);
        bit seen_done;
        seen_done = 1'b0;
        for (int n = 0; n < 200; n++) begin
            start = (n == 0) || (n == ign_n);
            for (int i = 0; i < int'(NC); i++) begin
                int unsigned step;
                step = (n >= int'(RH) + 1) ? (n - RH - 1) : 0;
                if (step > park[i]) step = park[i];
                core_pc[i*PW +: PW] = 32'h3000 + 4 * step;
            end
            @(posedge clk);
            @(negedge clk);
            if (n == 0) begin
                check("start_busy", busy, 1);
                check("start_done", done, 0);
                check("start_timeout", timeout, 0);
                check("start_cycle_cnt", cycle_cnt, 0);
                check("start_halted", halted, 0);
                check("start_core_rst", core_rst, 4'hF);
            end
            if (n == int'(RH) - 1) check("hold_last_core_rst", core_rst, 4'hF);
            if (n == int'(RH)) begin
                check("run_entry_core_rst", core_rst, 0);
                check("run_entry_cycle_cnt", cycle_cnt, 0);
            end
            if (n == int'(RH) + 1) check("first_run_cycle_cnt", cycle_cnt, 1);
            if (n == abort_n) begin
                #2 reset = 1'b0;
                #1;
                check("abort_core_rst", core_rst, 4'hF);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_cycle_cnt", cycle_cnt, 0);
                check("abort_halted", halted, 0);
                start = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            if (done) begin
                seen_done = 1'b1;
                check("done_busy_low", busy, 0);
                break;
            end
        end
        start = 1'b0;
        if (!seen_done) begin
            checks++;
            errors++;
            $display("FAIL run_wait: got no done within 200 cycles expected done");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b0;
        start   = 1'b1;
        core_pc = {NC{32'h3000}};
        repeat (3) @(negedge clk);
        check("reset_core_rst", core_rst, 4'hF);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_timeout", timeout, 0);
        check("reset_cycle_cnt", cycle_cnt, 0);
        check("reset_halted", halted, 0);
        reset = 1'b1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_core_rst", core_rst, 4'hF);
        check("idle_done", done, 0);

        // Basic run: every core walks 0x3000.. and parks at 0x3020
        hq.push_back('{halted: 4'hF, cnt: 16'd12});
        dq.push_back('{to: 1'b0, halted: 4'hF, cnt: 16'd12, hpc: {4{32'h3020}}});
        do_run({8'd8, 8'd8, 8'd8, 8'd8}, -1, -1);

        // Multi-core, staggered parks; start during HOLD is ignored
        hq.push_back('{halted: 4'b0001, cnt: 16'd6});
        hq.push_back('{halted: 4'b0011, cnt: 16'd9});
        hq.push_back('{halted: 4'b0111, cnt: 16'd13});
        hq.push_back('{halted: 4'b1111, cnt: 16'd18});
        dq.push_back('{to: 1'b0, halted: 4'hF, cnt: 16'd18,
                       hpc: {32'h3038, 32'h3024, 32'h3014, 32'h3008}});
        do_run({8'd14, 8'd9, 8'd5, 8'd2}, 2, -1);

        // Timeout: no core ever parks
        dq.push_back('{to: 1'b1, halted: 4'h0, cnt: 16'd50, hpc: '0});
        do_run({8'd255, 8'd255, 8'd255, 8'd255}, -1, -1);

        // Last halt lands on the MAX_CYCLES edge; start during RUN is ignored
        hq.push_back('{halted: 4'b0001, cnt: 16'd14});
        hq.push_back('{halted: 4'b0111, cnt: 16'd24});
        hq.push_back('{halted: 4'b1111, cnt: 16'd50});
        dq.push_back('{to: 1'b0, halted: 4'hF, cnt: 16'd50,
                       hpc: {32'h30B8, 32'h3050, 32'h3050, 32'h3028}});
        do_run({8'd46, 8'd20, 8'd20, 8'd10}, 20, -1);

        // Abort mid-RUN with asynchronous reset
        do_run({8'd255, 8'd255, 8'd255, 8'd255}, -1, 15);
        repeat (2) @(negedge clk);
        check("post_abort_busy", busy, 0);
        check("post_abort_core_rst", core_rst, 4'hF);

        // Recovery run after abort
        hq.push_back('{halted: 4'hF, cnt: 16'd12});
        dq.push_back('{to: 1'b0, halted: 4'hF, cnt: 16'd12, hpc: {4{32'h3020}}});
        do_run({8'd8, 8'd8, 8'd8, 8'd8}, -1, -1);

        repeat (3) @(negedge clk);
        check("halt_queue_drained", hq.size(), 0);
        check("done_queue_drained", dq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
